// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg
//   Shared encodings for the MIPS data-memory controller.
//   - access size codes (SZ_*), where the spare code 2'b11 behaves as a word
//   - FSM state codes (ST_*)
//   - wait-state limit and the width of the wait counter derived from it
//   - misalignment helper used by the lane unit
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE     = 2'b00;
  localparam logic [1:0] SZ_HALF     = 2'b01;
  localparam logic [1:0] SZ_WORD     = 2'b10;
  localparam logic [1:0] SZ_WORD_ALT = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int WAIT_STATES_MAX = 15;
  localparam int CNT_W           = $clog2(WAIT_STATES_MAX + 1);

  // Halfwords need an even address and words a 4-byte aligned address.
  // Bytes are never misaligned. Both word codes are treated the same way.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE:     mis = 1'b0;
      SZ_HALF:     mis = addr_lo[0];
      SZ_WORD:     mis = (addr_lo != 2'b00);
      SZ_WORD_ALT: mis = (addr_lo != 2'b00);
      default:     mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// dmem_lane_unit
//   Purely combinational steering between the CPU and a 32-bit little-endian word.
//   Lane k is bits [8k+7:8k], where k = addr_lo.
//   Inputs:
//     size        access size code
//     addr_lo     low two address bits
//     wdata       right-justified store data
//     unsigned_ld 1 = zero-extend loads, 0 = sign-extend loads
//     rd_word     current contents of the addressed word
//   Outputs:
//     byte_en     per-lane write enable
//     wr_word     store data shifted into its lanes
//     ld_word     extracted, right-justified and extended load data
//     misalign    access is misaligned; byte_en and ld_word are then zero
import mips_mem_pkg::*;

module dmem_lane_unit (
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic        unsigned_ld,
  input  logic [31:0] rd_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_word,
  output logic [31:0] ld_word,
  output logic        misalign
);

  logic [4:0]  shift_s;
  logic [15:0] lane_rd_s;

  // Lane selection, store shifting and load extension for one access
  always_comb begin
    shift_s   = {addr_lo, 3'b000};
    lane_rd_s = 16'(rd_word >> shift_s);
    byte_en   = 4'b0000;
    wr_word   = 32'd0;
    ld_word   = 32'd0;
    misalign  = is_misaligned(size, addr_lo);
    case (size)
      SZ_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
        wr_word = {24'd0, wdata[7:0]} << shift_s;
        if (unsigned_ld) begin
          ld_word = {24'd0, lane_rd_s[7:0]};
        end else begin
          ld_word = {{24{lane_rd_s[7]}}, lane_rd_s[7:0]};
        end
      end
      SZ_HALF: begin
        if (misalign) begin
          byte_en = 4'b0000;
        end else begin
          byte_en = 4'b0011 << addr_lo;
          wr_word = {16'd0, wdata[15:0]} << shift_s;
          if (unsigned_ld) begin
            ld_word = {16'd0, lane_rd_s};
          end else begin
            ld_word = {{16{lane_rd_s[15]}}, lane_rd_s};
          end
        end
      end
      default: begin
        // SZ_WORD and SZ_WORD_ALT: whole word, extension mode is irrelevant
        if (misalign) begin
          byte_en = 4'b0000;
        end else begin
          byte_en = 4'b1111;
          wr_word = wdata;
          ld_word = rd_word;
        end
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
//   Byte-addressable data memory for the MEM stage, with a req/done handshake
//   and a configurable number of wait states.
//   Parameters:
//     DEPTH_LOG2   log2 of the number of 32-bit words
//     WAIT_STATES  extra cycles between accept and done (0..15)
//     INIT_FILE    optional initial image name; contents start undefined
//   Ports:
//     clock, reset                 single clock; synchronous active-high reset
//     req, we, size, unsigned_ld   access request and its attributes
//     addr, wdata                  byte address and right-justified store data
//     rdata                        load result, held until the next load or misalign
//     done                         one-cycle completion pulse
//     misalign                     qualifies done; the access was not performed
//     busy                         access in flight (WAIT state)
import mips_mem_pkg::*;

module data_mem_ctrl #(
  parameter int DEPTH_LOG2  = 6,
  parameter int WAIT_STATES = 0,
  parameter     INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misalign,
  output logic        busy
);

  localparam int AW    = DEPTH_LOG2 + 2;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES - 1);

  logic [1:0]       state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;

  logic        we_r, unsigned_ld_r;
  logic [1:0]  size_r;
  logic [AW-1:0] addr_r;
  logic [31:0] wdata_r;

  logic [31:0] rdata_r;
  logic        done_r, misalign_r, busy_r;

  logic        op_we_s, op_unsigned_s;
  logic [1:0]  op_size_s;
  logic [AW-1:0] op_addr_s;
  logic [31:0] op_wdata_s;

  logic [DEPTH_LOG2-1:0] idx_s;
  logic [31:0] rd_word_s, wr_word_s, ld_word_s;
  logic [3:0]  byte_en_s;
  logic        lane_mis_s;

  logic capture_s, complete_s, mis_set_s, mem_we_s;
  logic unused_addr_s;

  logic [31:0] mem_r [0:DEPTH-1];

  // Address bits above the array wrap around by design
  assign unused_addr_s = ^addr[31:AW];

  // Operand source: live inputs when accepting, captured copies while waiting
  always_comb begin
    if (state_r == ST_WAIT) begin
      op_we_s       = we_r;
      op_size_s     = size_r;
      op_unsigned_s = unsigned_ld_r;
      op_addr_s     = addr_r;
      op_wdata_s    = wdata_r;
    end else begin
      op_we_s       = we;
      op_size_s     = size;
      op_unsigned_s = unsigned_ld;
      op_addr_s     = addr[AW-1:0];
      op_wdata_s    = wdata;
    end
  end

  assign idx_s     = op_addr_s[AW-1:2];
  assign rd_word_s = mem_r[idx_s];

  dmem_lane_unit u_lane (
    .size        (op_size_s),
    .addr_lo     (op_addr_s[1:0]),
    .wdata       (op_wdata_s),
    .unsigned_ld (op_unsigned_s),
    .rd_word     (rd_word_s),
    .byte_en     (byte_en_s),
    .wr_word     (wr_word_s),
    .ld_word     (ld_word_s),
    .misalign    (lane_mis_s)
  );

  // Next-state, wait-counter and access-completion decode
  always_comb begin
    state_nx_s = ST_IDLE;
    cnt_nx_s   = cnt_r;
    capture_s  = 1'b0;
    complete_s = 1'b0;
    mis_set_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (req) begin
          capture_s = 1'b1;
          if (lane_mis_s) begin
            state_nx_s = ST_DONE;
            mis_set_s  = 1'b1;
          end else if (WAIT_STATES == 0) begin
            state_nx_s = ST_DONE;
            complete_s = 1'b1;
          end else begin
            state_nx_s = ST_WAIT;
            cnt_nx_s   = WAIT_LOAD;
          end
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // New requests are ignored here; the requester holds off on busy
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_nx_s = ST_DONE;
          complete_s = 1'b1;
        end else begin
          state_nx_s = ST_WAIT;
          cnt_nx_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Reset wins over a completing store on the same edge
  assign mem_we_s = complete_s & op_we_s & ~reset;

  // Control state, captured operands and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      we_r          <= 1'b0;
      size_r        <= 2'b00;
      unsigned_ld_r <= 1'b0;
      addr_r        <= {AW{1'b0}};
      wdata_r       <= 32'd0;
      rdata_r       <= 32'd0;
      done_r        <= 1'b0;
      misalign_r    <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      cnt_r      <= cnt_nx_s;
      done_r     <= (state_nx_s == ST_DONE);
      busy_r     <= (state_nx_s == ST_WAIT);
      misalign_r <= mis_set_s;
      if (capture_s) begin
        we_r          <= we;
        size_r        <= size;
        unsigned_ld_r <= unsigned_ld;
        addr_r        <= addr[AW-1:0];
        wdata_r       <= wdata;
      end
      // Stores leave rdata alone; a misaligned access clears it
      if (mis_set_s) begin
        rdata_r <= 32'd0;
      end else if (complete_s && !op_we_s) begin
        rdata_r <= ld_word_s;
      end
    end
  end

  // Byte-enabled RAM write; contents survive reset
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en_s[k]) begin
          mem_r[idx_s][8*k +: 8] <= wr_word_s[8*k +: 8];
        end
      end
    end
  end

  assign rdata    = rdata_r;
  assign done     = done_r;
  assign misalign = misalign_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl
//   Three controllers share clock, reset and operand inputs, each with its own req:
//     index 0: WAIT_STATES = 0
//     index 1: WAIT_STATES = 3
//     index 2: WAIT_STATES = 2
//   A byte-level memory model computes the expected result of each access. The
//   expectation is queued when the request is driven and popped when done appears.
import mips_mem_pkg::*;

module tb_data_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        req_v    [3];
  logic [31:0] rdata_v  [3];
  logic        done_v   [3];
  logic        mis_v    [3];
  logic        busy_v   [3];

  int checks = 0;
  int errors = 0;

  int ws_c [3] = '{0, 3, 2};

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          busy_n;
  } exp_t;

  exp_t sb_q [$];

  logic [7:0]  mdl     [3][256];
  logic [31:0] last_rd [3];

  always #5 clock = ~clock;

  data_mem_ctrl #(.DEPTH_LOG2(6), .WAIT_STATES(0), .INIT_FILE("")) dut_a (
    .clock(clock), .reset(reset), .req(req_v[0]), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .rdata(rdata_v[0]),
    .done(done_v[0]), .misalign(mis_v[0]), .busy(busy_v[0]));

  data_mem_ctrl #(.DEPTH_LOG2(6), .WAIT_STATES(3), .INIT_FILE("")) dut_b (
    .clock(clock), .reset(reset), .req(req_v[1]), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .rdata(rdata_v[1]),
    .done(done_v[1]), .misalign(mis_v[1]), .busy(busy_v[1]));

  data_mem_ctrl #(.DEPTH_LOG2(6), .WAIT_STATES(2), .INIT_FILE("")) dut_c (
    .clock(clock), .reset(reset), .req(req_v[2]), .we(we), .size(size),
    .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata), .rdata(rdata_v[2]),
    .done(done_v[2]), .misalign(mis_v[2]), .busy(busy_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Reference model: little-endian bytes, address wraps at 256 bytes
  task automatic model_op(input int d, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic mis);
    int b;
    int base;
    b    = int'(a[7:0]);
    base = int'({a[7:2], 2'b00});
    mis  = ((sz == 2'b01) && a[0]) || (sz[1] && (a[1:0] != 2'b00));
    if (mis) begin
      rd = 32'd0;
    end else if (w) begin
      rd = last_rd[d];
      if (sz == 2'b00) begin
        mdl[d][b] = wd[7:0];
      end else if (sz == 2'b01) begin
        mdl[d][b]   = wd[7:0];
        mdl[d][b+1] = wd[15:8];
      end else begin
        for (int k = 0; k < 4; k++) mdl[d][base+k] = wd[8*k +: 8];
      end
    end else begin
      if (sz == 2'b00) begin
        rd = u ? {24'd0, mdl[d][b]} : {{24{mdl[d][b][7]}}, mdl[d][b]};
      end else if (sz == 2'b01) begin
        rd = u ? {16'd0, mdl[d][b+1], mdl[d][b]}
               : {{16{mdl[d][b+1][7]}}, mdl[d][b+1], mdl[d][b]};
      end else begin
        rd = {mdl[d][base+3], mdl[d][base+2], mdl[d][base+1], mdl[d][base]};
      end
    end
    last_rd[d] = rd;
  endtask

  // Called on a falling edge. Drives one request; with poke set, req is
  // re-asserted with scrambled operands while the DUT reports busy.
  // Returns on the falling edge where done was seen.
  task automatic do_access(input int d, input logic w, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd, input bit poke);
    exp_t e;
    exp_t got;
    int   edges;
    int   busy_n;
    bit   seen;
    model_op(d, w, sz, u, a, wd, e.rd, e.mis);
    e.lat    = e.mis ? 1 : ws_c[d] + 1;
    e.busy_n = e.mis ? 0 : ws_c[d];
    sb_q.push_back(e);
    we = w; size = sz; unsigned_ld = u; addr = a; wdata = wd;
    req_v[d] = 1'b1;
    edges = 0; busy_n = 0; seen = 1'b0;
    while (!seen && edges < 64) begin
      @(posedge clock);
      edges++;
      @(negedge clock);
      if (busy_v[d]) begin
        busy_n++;
        if (poke) begin
          req_v[d] = 1'b1;
          we       = ~w;
          size     = 2'($urandom_range(3, 0));
          addr     = $urandom;
          wdata    = $urandom;
        end else begin
          req_v[d] = 1'b0;
        end
      end else begin
        req_v[d] = 1'b0;
      end
      if (done_v[d]) seen = 1'b1;
    end
    req_v[d] = 1'b0;
    chk1("done_timeout", seen, 1'b1);
    got = sb_q.pop_front();
    chk("rdata", rdata_v[d], got.rd);
    chk1("misalign", mis_v[d], got.mis);
    chk("latency", edges, got.lat);
    chk("busy_cycles", busy_n, got.busy_n);
  endtask

  initial begin
    reset = 1'b1; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    for (int d = 0; d < 3; d++) begin
      req_v[d]   = 1'b0;
      last_rd[d] = 32'd0;
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_rdata", rdata_v[d], 32'd0);
      chk1("rst_done", done_v[d], 1'b0);
      chk1("rst_misalign", mis_v[d], 1'b0);
      chk1("rst_busy", busy_v[d], 1'b0);
    end

    // Zero wait states: word store/load, then the calls chain back-to-back in DONE
    do_access(0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, 1'b0);
    do_access(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("lw_const", rdata_v[0], 32'h11223344);
    @(negedge clock);
    chk("rdata_hold", rdata_v[0], 32'h11223344);
    chk1("done_drop", done_v[0], 1'b0);

    do_access(0, 1'b1, SZ_BYTE, 1'b0, 32'h13, 32'hFFFF_FFAB, 1'b0);
    chk("store_keeps_rdata", rdata_v[0], 32'h11223344);
    do_access(0, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0);
    chk("sb_merge_const", rdata_v[0], 32'hAB223344);
    do_access(0, 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 1'b0);
    chk("lb_const", rdata_v[0], 32'hFFFFFFAB);
    do_access(0, 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 1'b0);
    chk("lbu_const", rdata_v[0], 32'h000000AB);
    do_access(0, 1'b0, SZ_BYTE, 1'b0, 32'h11, 32'h0, 1'b0);

    do_access(0, 1'b1, SZ_WORD, 1'b0, 32'h14, 32'h55667788, 1'b0);
    do_access(0, 1'b1, SZ_HALF, 1'b0, 32'h16, 32'h1234_8001, 1'b0);
    do_access(0, 1'b0, SZ_HALF, 1'b0, 32'h16, 32'h0, 1'b0);
    chk("lh_const", rdata_v[0], 32'hFFFF8001);
    do_access(0, 1'b0, SZ_HALF, 1'b1, 32'h16, 32'h0, 1'b0);
    chk("lhu_const", rdata_v[0], 32'h00008001);
    do_access(0, 1'b0, SZ_HALF, 1'b0, 32'h14, 32'h0, 1'b0);
    do_access(0, 1'b0, SZ_HALF, 1'b0, 32'h15, 32'h0, 1'b0);
    do_access(0, 1'b1, SZ_WORD, 1'b0, 32'h16, 32'hFFFFFFFF, 1'b0);
    do_access(0, 1'b1, SZ_HALF, 1'b0, 32'h13, 32'hFFFFFFFF, 1'b0);
    do_access(0, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 1'b0);
    chk("misalign_no_write", rdata_v[0], 32'h80017788);

    // Aliasing: upper address bits ignored; size 2'b11 acts as a word
    do_access(0, 1'b1, SZ_WORD, 1'b0, 32'h100, 32'h0BADF00D, 1'b0);
    do_access(0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
    chk("alias_const", rdata_v[0], 32'h0BADF00D);
    do_access(0, 1'b0, SZ_WORD_ALT, 1'b1, 32'hFFFF_FF00, 32'h0, 1'b0);
    do_access(0, 1'b1, SZ_BYTE, 1'b0, 32'h102, 32'h5A, 1'b0);
    do_access(0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 1'b0);
    @(negedge clock);

    // Three wait states: busy for three cycles, requests during busy ignored
    do_access(1, 1'b1, SZ_WORD, 1'b0, 32'h40, 32'hA5A51234, 1'b0);
    do_access(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b1);
    do_access(1, 1'b1, SZ_HALF, 1'b0, 32'h42, 32'h0000C3C3, 1'b1);
    do_access(1, 1'b0, SZ_WORD, 1'b0, 32'h42, 32'h0, 1'b0);
    do_access(1, 1'b0, SZ_HALF, 1'b1, 32'h42, 32'h0, 1'b1);
    do_access(1, 1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0);
    chk("ws3_final_const", rdata_v[1], 32'hC3C31234);
    @(negedge clock);

    // Two wait states: reset on the completing edge of a store
    do_access(2, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0);
    @(negedge clock);
    we = 1'b1; size = SZ_WORD; unsigned_ld = 1'b0; addr = 32'h20; wdata = 32'hDEADBEEF;
    req_v[2] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_v[2] = 1'b0;
    chk1("inflight_busy", busy_v[2], 1'b1);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    chk1("abort_done", done_v[2], 1'b0);
    chk1("abort_busy", busy_v[2], 1'b0);
    chk("abort_rdata", rdata_v[2], 32'd0);
    chk1("abort_misalign", mis_v[2], 1'b0);
    for (int d = 0; d < 3; d++) last_rd[d] = 32'd0;
    do_access(2, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0);
    chk("abort_old_data", rdata_v[2], 32'hCAFEF00D);
    do_access(0, 1'b0, SZ_WORD, 1'b0, 32'h14, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
